// File: rtl/branch_predictor.sv
// Fetch-side dynamic branch predictor: direct-mapped table of 2-bit saturating
// counters with branch targets. Predicts in F, resolves in D, updates one edge later.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f,
  output logic        predict_taken_f,
  output logic [31:0] predict_pc_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        branch_d,
  input  logic        taken_d,
  input  logic [31:0] branch_target_d,
  output logic        predict_miss,
  output logic [31:0] correct_pc
);

  localparam int unsigned Entries = 1 << INDEX_BITS;

  // Table storage
  logic                valid_q  [Entries];
  logic [1:0]          ctr_q    [Entries];
  logic [TAG_BITS-1:0] tag_q    [Entries];
  logic [31:0]         target_q [Entries];

  // D-stage register
  logic [31:0] pc_d_q;
  logic        pred_taken_d_q;
  logic [31:0] pred_target_d_q;
  logic        hit_d_q;

  logic [INDEX_BITS-1:0] idx_f, idx_d;
  logic [TAG_BITS-1:0]   tag_f, tag_d;
  logic                  hit_f;
  logic [31:0]           pc_f_plus4, pc_d_plus4;
  logic                  resolve;
  logic                  branch_miss, stale_miss;
  logic                  entry_hit_d;
  logic                  stale_d;
  logic [1:0]            ctr_next;

  assign idx_f = pc_f[INDEX_BITS+1:2];
  assign tag_f = pc_f[31:INDEX_BITS+2];
  assign idx_d = pc_d_q[INDEX_BITS+1:2];
  assign tag_d = pc_d_q[31:INDEX_BITS+2];

  assign pc_f_plus4 = pc_f + 32'd4;
  assign pc_d_plus4 = pc_d_q + 32'd4;

  // Fetch-stage lookup and next-PC prediction
  always_comb begin
    hit_f           = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    predict_taken_f = hit_f && ctr_q[idx_f][1];
    predict_pc_f    = predict_taken_f ? target_q[idx_f] : pc_f_plus4;
  end

  // D-stage pipeline register: stall holds, flush clears, else capture fetch prediction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_d_q          <= 32'd0;
      pred_taken_d_q  <= 1'b0;
      pred_target_d_q <= 32'd0;
      hit_d_q         <= 1'b0;
    end else if (stall_d) begin
      pc_d_q          <= pc_d_q;
    end else if (flush_d) begin
      pc_d_q          <= 32'd0;
      pred_taken_d_q  <= 1'b0;
      pred_target_d_q <= 32'd0;
      hit_d_q         <= 1'b0;
    end else begin
      pc_d_q          <= pc_f;
      pred_taken_d_q  <= predict_taken_f;
      pred_target_d_q <= predict_pc_f;
      hit_d_q         <= hit_f;
    end
  end

  // Resolution of the D-stage prediction; gated off while stalled or in reset
  always_comb begin
    resolve     = !stall_d && rst_n;
    // A predicted-taken non-branch implies the fetch hit a stale entry
    stale_d     = !branch_d && hit_d_q && pred_taken_d_q;
    branch_miss = branch_d && resolve &&
                  ((taken_d != pred_taken_d_q) ||
                   (taken_d && (pred_target_d_q != branch_target_d)));
    stale_miss  = resolve && stale_d;
    predict_miss = branch_miss || stale_miss;
    correct_pc   = (branch_d && taken_d) ? branch_target_d : pc_d_plus4;
  end

  // Live lookup for the update: an intervening write may have changed the entry since fetch
  always_comb begin
    entry_hit_d = valid_q[idx_d] && (tag_q[idx_d] == tag_d);
    ctr_next    = ctr_q[idx_d];
    if (taken_d) begin
      if (ctr_q[idx_d] != 2'b11) ctr_next = ctr_q[idx_d] + 2'b01;
    end else begin
      if (ctr_q[idx_d] != 2'b00) ctr_next = ctr_q[idx_d] - 2'b01;
    end
  end

  // Valid bits and counters: train on hit, allocate weakly-taken on taken miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (resolve) begin
      if (branch_d) begin
        if (entry_hit_d) begin
          ctr_q[idx_d] <= ctr_next;
        end else if (taken_d) begin
          valid_q[idx_d] <= 1'b1;
          ctr_q[idx_d]   <= 2'b10;
        end
      end else if (stale_d) begin
        valid_q[idx_d] <= 1'b0;
      end
    end
  end

  // Tag and target only matter while valid, so they need no reset
  always_ff @(posedge clk) begin
    if (resolve && branch_d && taken_d) begin
      tag_q[idx_d]    <= tag_d;
      target_q[idx_d] <= branch_target_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        predict_taken_f;
  logic [31:0] predict_pc_f;
  logic        stall_d;
  logic        flush_d;
  logic        branch_d;
  logic        taken_d;
  logic [31:0] branch_target_d;
  logic        predict_miss;
  logic [31:0] correct_pc;

  int checks = 0;
  int errors = 0;

  branch_predictor dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_f            (pc_f),
    .predict_taken_f (predict_taken_f),
    .predict_pc_f    (predict_pc_f),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .branch_d        (branch_d),
    .taken_d         (taken_d),
    .branch_target_d (branch_target_d),
    .predict_miss    (predict_miss),
    .correct_pc      (correct_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Apply one cycle's inputs, then let combinational outputs settle
  task automatic drive(input logic [31:0] pc, input logic st, input logic fl,
                       input logic br, input logic tk, input logic [31:0] tgt);
    pc_f            = pc;
    stall_d         = st;
    flush_d         = fl;
    branch_d        = br;
    taken_d         = tk;
    branch_target_d = tgt;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(32'h40, 0, 0, 0, 0, 32'h0);
    check("rst_pt", {31'd0, predict_taken_f}, 32'd0);
    check("rst_ppc", predict_pc_f, 32'h44);
    check("rst_miss", {31'd0, predict_miss}, 32'd0);
    #10 rst_n = 1'b1;
    tick();                                           // D <= 0x40, not predicted

    // Cold taken branch at 0x40 -> allocate weakly taken
    drive(32'h44, 0, 0, 1, 1, 32'h100);
    check("cold_miss", {31'd0, predict_miss}, 32'd1);
    check("cold_cpc", correct_pc, 32'h100);
    tick();
    drive(32'h40, 0, 0, 0, 0, 32'h0);
    check("warm_miss", {31'd0, predict_miss}, 32'd0);
    check("warm_pt", {31'd0, predict_taken_f}, 32'd1);
    check("warm_ppc", predict_pc_f, 32'h100);
    tick();
    // Resolve taken again; fetch alias 0x140 (same index, other tag)
    drive(32'h140, 0, 0, 1, 1, 32'h100);
    check("hit_taken_miss", {31'd0, predict_miss}, 32'd0);
    check("alias_pt", {31'd0, predict_taken_f}, 32'd0);
    check("alias_ppc", predict_pc_f, 32'h144);
    tick();
    drive(32'h40, 0, 0, 0, 0, 32'h0);
    check("ctr_sat", {30'd0, dut.ctr_q[16]}, 32'd3);
    check("strong_pt", {31'd0, predict_taken_f}, 32'd1);
    tick();

    // Hysteresis: two not-taken resolutions
    drive(32'h200, 0, 0, 1, 0, 32'h0);
    check("nt1_miss", {31'd0, predict_miss}, 32'd1);
    check("nt1_cpc", correct_pc, 32'h44);
    tick();
    drive(32'h40, 0, 0, 0, 0, 32'h0);
    check("weak_pt", {31'd0, predict_taken_f}, 32'd1);
    tick();
    drive(32'h200, 0, 0, 1, 0, 32'h0);
    check("nt2_miss", {31'd0, predict_miss}, 32'd1);
    check("nt2_cpc", correct_pc, 32'h44);
    tick();
    drive(32'h40, 0, 0, 0, 0, 32'h0);
    check("wnt_pt", {31'd0, predict_taken_f}, 32'd0);
    check("wnt_ppc", predict_pc_f, 32'h44);
    tick();
    drive(32'h140, 0, 0, 1, 0, 32'h0);
    check("nt_ok_miss", {31'd0, predict_miss}, 32'd0);
    tick();

    // Alias replacement: taken branch at 0x140 evicts 0x40
    drive(32'h40, 0, 0, 1, 1, 32'h300);
    check("alias_alloc_miss", {31'd0, predict_miss}, 32'd1);
    check("alias_alloc_cpc", correct_pc, 32'h300);
    tick();
    drive(32'h40, 0, 0, 0, 0, 32'h0);
    check("evicted_pt", {31'd0, predict_taken_f}, 32'd0);
    check("evicted_ppc", predict_pc_f, 32'h44);
    tick();
    drive(32'h140, 0, 0, 0, 0, 32'h0);
    check("new_pt", {31'd0, predict_taken_f}, 32'd1);
    check("new_ppc", predict_pc_f, 32'h300);
    tick();                                           // D <= 0x140 predicted taken

    // Stall with toggling outcome: no miss, no state change
    drive(32'h500, 1, 0, 1, 1, 32'h999);
    check("stall1_miss", {31'd0, predict_miss}, 32'd0);
    tick();
    drive(32'h500, 1, 0, 1, 0, 32'h0);
    check("stall2_miss", {31'd0, predict_miss}, 32'd0);
    check("stall_pcd", dut.pc_d_q, 32'h140);
    check("stall_ctr", {30'd0, dut.ctr_q[16]}, 32'd2);
    tick();
    drive(32'h500, 0, 0, 1, 0, 32'h0);
    check("release_miss", {31'd0, predict_miss}, 32'd1);
    check("release_cpc", correct_pc, 32'h144);
    tick();
    drive(32'h140, 0, 0, 0, 0, 32'h0);
    check("one_update_ctr", {30'd0, dut.ctr_q[16]}, 32'd1);
    check("one_update_pt", {31'd0, predict_taken_f}, 32'd0);
    tick();
    drive(32'h500, 0, 0, 1, 1, 32'h300);
    check("retrain_miss", {31'd0, predict_miss}, 32'd1);
    tick();

    // Flush after predicted-taken fetch
    drive(32'h140, 0, 1, 0, 0, 32'h0);
    check("pre_flush_pt", {31'd0, predict_taken_f}, 32'd1);
    tick();
    drive(32'h140, 0, 0, 0, 0, 32'h0);
    check("flush_pred", {31'd0, dut.pred_taken_d_q}, 32'd0);
    check("flush_miss", {31'd0, predict_miss}, 32'd0);
    check("flush_cpc", correct_pc, 32'h4);
    tick();
    // Stale predicted-taken non-branch
    drive(32'h600, 0, 0, 0, 0, 32'h0);
    check("stale_miss", {31'd0, predict_miss}, 32'd1);
    check("stale_cpc", correct_pc, 32'h144);
    tick();
    drive(32'h140, 0, 0, 1, 1, 32'h700);
    check("inval_pt", {31'd0, predict_taken_f}, 32'd0);
    check("inval_ppc", predict_pc_f, 32'h144);
    check("idx0_alloc_miss", {31'd0, predict_miss}, 32'd1);
    tick();
    drive(32'h600, 0, 0, 0, 0, 32'h0);
    check("idx0_pt", {31'd0, predict_taken_f}, 32'd1);
    check("idx0_ppc", predict_pc_f, 32'h700);

    // Reset mid-cycle with a branch in D
    #1 rst_n = 1'b0;
    branch_d = 1'b1;
    taken_d  = 1'b1;
    branch_target_d = 32'h123;
    #1;
    check("midrst_pt", {31'd0, predict_taken_f}, 32'd0);
    check("midrst_ppc", predict_pc_f, 32'h604);
    check("midrst_miss", {31'd0, predict_miss}, 32'd0);
    #1 rst_n = 1'b1;
    drive(32'h600, 0, 0, 0, 0, 32'h0);
    check("postrst_pt", {31'd0, predict_taken_f}, 32'd0);
    tick();
    drive(32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0);
    check("wrap_ppc", predict_pc_f, 32'h0);
    check("wrap_pt", {31'd0, predict_taken_f}, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side dynamic branch predictor: direct-mapped BHT/BTB of 2-bit saturating counters with branch targets.
- Produces the fetch-stage next-PC prediction.
- Resolves that prediction when the branch reaches decode and drives `predict_miss` and the corrected PC into the hazard unit and PC mux.
- Sits between the PC register, the F/D pipeline register and the decode-stage branch comparator.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64); index = pc[INDEX_BITS+1:2]
- TAG_BITS, 30-INDEX_BITS, tag = pc[31:INDEX_BITS+2]; full tag, no aliasing between distinct PCs

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- pc_f  input  32  fetch-stage PC
- predict_taken_f  output  1  prediction for pc_f: taken
- predict_pc_f  output  32  predicted next PC (BTB target if taken, else pc_f+4)
- stall_d  input  1  decode stall from hazard unit; holds D-stage state
- flush_d  input  1  decode flush from hazard unit; clears D-stage state
- branch_d  input  1  instruction in D is a conditional branch
- taken_d  input  1  resolved branch outcome in D
- branch_target_d  input  32  resolved branch target in D
- predict_miss  output  1  D-stage prediction wrong; redirect fetch
- correct_pc  output  32  redirect address, valid when predict_miss=1

Behaviour:
- Entry fields: valid, tag, target[31:0], ctr[1:0].
- Reset (async, rst_n=0):
  - all valid=0, ctr=2'b01, D-stage register cleared.
  - predict_taken_f=0, predict_miss=0, predict_pc_f=pc_f+4.
- Fetch (combinational):
  - hit = valid[idx_f] && tag[idx_f]==tag(pc_f).
  - predict_taken_f = hit && ctr[1].
  - predict_pc_f = predict_taken_f ? target : pc_f+4.
- D-stage register (posedge):
  - Fields: pc_d, pred_taken_d, pred_target_d, hit_d.
  - stall_d=1: hold.
  - else flush_d=1: clear (pred_taken_d=0, hit_d=0, pc_d=0).
  - else load from fetch.
  - stall_d has priority over flush_d.
- Resolution (combinational), resolve = !stall_d && !rst_n-asserted:
  - Branch mispredict: branch_d && resolve && (taken_d != pred_taken_d || (taken_d && pred_target_d != branch_target_d)).
  - Non-branch predicted taken: !branch_d && resolve && pred_taken_d (stale entry).
  - predict_miss = either of the above.
  - correct_pc = (branch_d && taken_d) ? branch_target_d : pc_d+4.
  - predict_miss is forced to 0 while stall_d=1 (operands not yet forwarded; outcome unreliable).
- Update (posedge, only when resolve; index/tag from pc_d):
  - Branch, entry hits: ctr saturating +1 if taken (max 2'b11), -1 if not (min 2'b00); target <= branch_target_d when taken.
  - Branch, entry misses, taken: allocate valid=1, tag, target, ctr=2'b10 (weakly taken), overwriting any occupant.
  - Branch, entry misses, not taken: no write.
  - Non-branch with pred_taken_d: valid[idx]<=0.
- Same-cycle read/write of one index: fetch sees the old entry; the new value is visible next cycle.
- Latency: prediction 0 cycles (same cycle as pc_f); miss reported in the cycle the branch is in D and not stalled; table write one edge later.
- Reset mid-operation clears the table and D-stage immediately; no partial updates survive.
- Widths: pc+4 is modulo 2^32 (0xFFFF_FFFC+4 wraps to 0).

Test Plan:
- Reset, pc_f=0x0000_0040 -> predict_taken_f=0, predict_pc_f=0x0000_0044.
- Cold taken branch at 0x40, target 0x100, taken_d=1 in D -> predict_miss=1, correct_pc=0x100. Next fetch of 0x40 -> predict_taken_f=1, predict_pc_f=0x100; resolving taken again -> predict_miss=0, ctr=2'b11.
- Counter hysteresis: from ctr=2'b11 at 0x40, resolve not-taken -> predict_miss=1, correct_pc=0x44, ctr=2'b10; next fetch still predicts taken. Second not-taken -> ctr=2'b01; next fetch predicts not taken.
- Alias: 0x140 maps to index 16 with a different tag while 0x40 is resident -> predict_taken_f=0. Taken 0x140 branch replaces the entry; a subsequent fetch of 0x40 misses.
- stall_d=1 for 2 cycles with branch_d=1, taken_d toggling -> predict_miss=0, D-stage and table unchanged. On release -> exactly one update and the correct miss decision.
- flush_d=1 after a predicted-taken fetch -> next cycle pred_taken_d=0. A non-branch now in D -> predict_miss=0. Separately, a stale predicted-taken non-branch -> predict_miss=1, correct_pc=pc_d+4, entry invalidated.
